seq_addsub: RTL and testbench

SEQ_ADDSUB -- requirements
Module: seq_addsub

---
 rtl/seq_addsub_pkg.sv | 33 +++
 rtl/seq_addsub_chunk_adder.sv | 36 +++
 rtl/seq_addsub.sv | 138 +++++++++++++
 tb/tb_seq_addsub.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// ---------------------------------------------------------------------------
// seq_addsub_pkg
// Shared definitions for the chunk-serial adder/subtractor:
//   state_e        - controller states (IDLE, RUN, DONE)
//   DEFAULT_*      - default operand width and chunk size
//   chunk_count()  - number of chunks N = width / chunk
//   chunk_legal()  - parameter legality (chunk divides width, non-zero)
//   idx_width()    - bits needed for the chunk index (at least 1)
// ---------------------------------------------------------------------------
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int chunk_count(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 0;
  endfunction

  function automatic bit chunk_legal(input int width, input int chunk);
    return (width > 0) && (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : seq_addsub_pkg

// File: rtl/seq_addsub_chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Purely combinational CHUNK-bit ripple-carry adder.
//   a, b   : chunk operands
//   ci     : carry in
//   sum    : chunk sum
//   co     : carry out of the chunk MSB
//   c_msb  : carry into the chunk MSB (feeds signed-overflow detection)
// ---------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = ci;
    c_msb = ci;
    sum   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        c_msb = c;
      end
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule : chunk_adder

// File: rtl/seq_addsub.sv
// ---------------------------------------------------------------------------
// seq_addsub
// Sequential adder/subtractor that processes CHUNK bits per clock, LSB chunk
// first, through one shared chunk_adder. Subtraction is A + ~B + 1.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, accepted while IDLE or DONE
//   sub   : 0 = a+b, 1 = a-b (sampled with start)
//   a, b  : operands (sampled with start)
//   busy  : high in RUN (exactly N cycles per operation)
//   done  : one-cycle pulse when s/co/ovf carry a fresh result
//   s     : result modulo 2^WIDTH, held until the next done
//   co    : carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf   : two's-complement signed overflow
// ---------------------------------------------------------------------------
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N     = chunk_count(WIDTH, CHUNK);
  localparam int IDX_W = idx_width(N);

  generate
    if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_params
      $error("seq_addsub: CHUNK must be non-zero and divide WIDTH");
    end
  endgenerate

  state_e                   state_q;
  state_e                   state_d;
  logic signed [WIDTH-1:0]  a_q;
  logic signed [WIDTH-1:0]  b_q;
  logic signed [WIDTH-1:0]  acc_q;
  logic signed [WIDTH-1:0]  acc_d;
  logic                     carry_q;
  logic [IDX_W-1:0]         idx_q;
  logic [CHUNK-1:0]         a_chunk;
  logic [CHUNK-1:0]         b_chunk;
  logic [CHUNK-1:0]         sum_chunk;
  logic                     c_out;
  logic                     c_msb;
  logic                     ready;
  logic                     accept;
  logic                     last;
  int                       base;

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept = ready && start;
  assign last   = (idx_q == IDX_W'(N - 1));
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);

  // Chunk select: slice the current chunk out of the latched operands and
  // merge the new sum chunk into the accumulator image.
  always_comb begin
    base    = int'(idx_q) * CHUNK;
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    acc_d   = acc_q;
    acc_d[base +: CHUNK] = sum_chunk;
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a     (a_chunk),
    .b     (b_chunk),
    .ci    (carry_q),
    .sum   (sum_chunk),
    .co    (c_out),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      // A start in DONE is taken straight away, giving back-to-back operation.
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture / chunk iteration: the accumulator is internal only;
  // s/co/ovf change solely on the edge that finishes the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      acc_q   <= '0;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q   <= acc_d;
      carry_q <= c_out;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        s   <= acc_d;
        co  <= c_out;
        ovf <= c_out ^ c_msb;
      end
    end
  end

endmodule : seq_addsub

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy1, done1, co1, ovf1;
  logic [15:0] s1;
  logic        busy2, done2, co2, ovf2;
  logic [15:0] s2;

  logic        sel;
  logic        m_busy, m_done, m_co, m_ovf;
  logic [15:0] m_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk (clk), .rst (rst), .start (start), .sub (sub), .a (a), .b (b),
    .busy (busy1), .done (done1), .s (s1), .co (co1), .ovf (ovf1)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk (clk), .rst (rst), .start (start), .sub (sub), .a (a), .b (b),
    .busy (busy2), .done (done2), .s (s2), .co (co2), .ovf (ovf2)
  );

  always_comb begin
    m_busy = sel ? busy2 : busy1;
    m_done = sel ? done2 : done1;
    m_s    = sel ? s2    : s1;
    m_co   = sel ? co2   : co1;
    m_ovf  = sel ? ovf2  : ovf1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues an operation at the current (negedge) time and waits for done.
  // chg: on the first RUN cycle present new operands with start high.
  // hold: leave start high afterwards (caller drops it).
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tsub, input logic [15:0] es, input logic eco,
                       input logic eovf, input int n, input bit chg, input bit hold,
                       input logic [15:0] ca, input logic [15:0] cb);
    int  cyc = 0;
    int  busy_cnt = 0;
    bit  got = 0;
    start = 1'b1;
    a     = ta;
    b     = tb;
    sub   = tsub;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (chg) begin
          a = ca;
          b = cb;
        end else if (!hold) begin
          start = 1'b0;
        end
      end
      if (cyc == 2 && chg && !hold) start = 1'b0;
      if (m_done) got = 1;
      else if (m_busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
    check({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
    check({tag, "_s"}, 32'(m_s), 32'(es));
    check({tag, "_co"}, 32'(m_co), 32'(eco));
    check({tag, "_ovf"}, 32'(m_ovf), 32'(eovf));
  endtask

  initial begin
    int dcnt;
    int bcnt;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    sel   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst4_busy", 32'(busy1), 32'd0);
    check("rst4_done", 32'(done1), 32'd0);
    check("rst4_s",    32'(s1),    32'd0);
    check("rst4_co",   32'(co1),   32'd0);
    check("rst4_ovf",  32'(ovf1),  32'd0);
    check("rst16_s",   32'(s2),    32'd0);
    check("rst16_done", 32'(done2), 32'd0);

    // Start driven together with reset release: taken on the first edge.
    rst = 1'b0;
    do_op("add_6_3", 16'h0006, 16'h0003, 1'b0, 16'h0009, 1'b0, 1'b0, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("add_6_3_done_pulse", 32'(m_done), 32'd0);
    check("add_6_3_s_held", 32'(m_s), 32'h0009);

    @(negedge clk);
    do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    do_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    do_op("sub_3_5", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    do_op("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);

    // Start with new operands during RUN must be ignored.
    do_op("run_ignore", 16'h0A0A, 16'h0505, 1'b0, 16'h0F0F, 1'b0, 1'b0, 4, 1, 0, 16'hFFFF, 16'hFFFF);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_done) dcnt++;
      if (m_busy) bcnt++;
    end
    check("run_ignore_no_extra_done", 32'(dcnt), 32'd0);
    check("run_ignore_no_extra_busy", 32'(bcnt), 32'd0);
    check("run_ignore_s_held", 32'(m_s), 32'h0F0F);

    // Start held through RUN into DONE: second op follows back-to-back.
    do_op("b2b_first", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 4, 1, 1, 16'h0100, 16'h0001);
    do_op("b2b_second", 16'h0100, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b0, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);

    do_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);

    // Reset in the second RUN cycle aborts the operation.
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_run1", 32'(busy1), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_s",    32'(s1),    32'd0);
    check("abort_co",   32'(co1),   32'd0);
    check("abort_ovf",  32'(ovf1),  32'd0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done1) dcnt++;
      if (busy1) bcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    check("abort_no_busy", 32'(bcnt), 32'd0);
    check("abort_s_still0", 32'(s1), 32'd0);
    do_op("after_abort", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 4, 0, 0, 16'h0, 16'h0);
    @(negedge clk);

    // Single-chunk configuration.
    sel = 1'b1;
    @(negedge clk);
    do_op("n1_add", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    do_op("n1_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_addsub
